mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the processor's data-memory port, alongside `dmem`. It consumes the core's store stream (`MemWrite`, `DataAdr`, `WriteData`) for its address window and queues bytes in a small FIFO. It serialises each byte as an 8N1 frame on `txd` and returns status combinationally on `rd`, so the single-cycle core can load status in the same cycle it addresses it. The top level gates `dmem` write-enable off whenever the address falls in this window.

---
 rtl/mmio_pkg.sv | 22 ++
 rtl/tx_fifo.sv | 52 +++++
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets (word index a[3:2]), STATUS bit positions and TX FSM states.
package mmio_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_ACTIVE    = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the UART transmit queue.
// Ports: clk, rst_n (async active-low), push_i/din_i (write side),
//        pop_i/dout_o (read side, dout_o shows the head combinationally),
//        full_o, empty_o, count_o (occupancy, one bit wider than the pointers).
// A push while full is accepted only when a pop happens in the same cycle.
// pop_i must only be asserted while the FIFO is non-empty.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             accept;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign accept  = push_i && (!full_o || pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(accept) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory port.
// Ports: clk, reset (async active-low), we/a/wd (core store stream),
//        rd (combinational read data for a), txd (serial out, idle high),
//        busy (queue non-empty or frame in progress).
// Registers (a[3:2] within the 16-byte window): TXDATA push, STATUS,
// CTRL.enable. txd is decoded from registered FSM state so reset forces it
// high immediately.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          en_q, en_d;
  logic          ovf_q, ovf_d;

  logic          hit, push_req, pop;
  logic [1:0]    sel;
  logic          full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          unused;

  assign hit      = (a[31:4] == ADDR_BASE[31:4]);
  assign sel      = a[3:2];
  assign push_req = we && hit && (sel == REG_TXDATA);
  assign unused   = ^{a[1:0], wd[31:8]};

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_req),
    .din_i   (wd[7:0]),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_q && !empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (en_q && !empty) begin
            pop     = 1'b1;
            shift_d = head;
            baud_d  = BAUD_LOAD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_d  = en_q;
    ovf_d = ovf_q;
    if (we && hit && (sel == REG_CTRL)) en_d = wd[0];
    if (push_req && full && !pop)
      ovf_d = 1'b1;
    else if (we && hit && (sel == REG_STATUS) && wd[ST_OVF])
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      en_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign busy = !empty || (state_q != S_IDLE);

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (sel)
        REG_STATUS: begin
          rd[ST_FULL]                    = full;
          rd[ST_EMPTY]                   = empty;
          rd[ST_ACTIVE]                  = (state_q != S_IDLE);
          rd[ST_OVF]                     = ovf_q;
          rd[ST_COUNT_LSB+3:ST_COUNT_LSB] = 4'(count);
        end
        REG_CTRL: rd[0] = en_q;
        default:  rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int unsigned  CPB  = 4;
  localparam logic [31:0]  BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        txd, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .ADDR_BASE    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .txd   (txd),
    .busy  (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1 chk(nm, rd, exp);
  endtask

  // Leaves the caller on the negedge where the start bit is first visible.
  task automatic wait_start(input string nm);
    int n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " start seen"}, {31'b0, txd}, 32'h0);
  endtask

  // Called on the first negedge sample of the start bit.
  task automatic check_frame(input logic [7:0] d, input string nm);
    logic [9:0] bits;
    logic       got;
    bits = {1'b1, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      got = bits[k];
      for (int j = 0; j < int'(CPB); j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        if (txd !== bits[k]) got = txd;
      end
      chk($sformatf("%s bit%0d", nm, k), {31'b0, got}, {31'b0, bits[k]});
    end
  endtask

  initial begin
    bit quiet;

    // Reset
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", {31'b0, txd}, 32'h1);
    chk("reset busy", {31'b0, busy}, 32'h0);
    reset = 1'b1;
    rd_check("reset status", BASE + 32'h4, 32'h02);
    rd_check("reset ctrl", BASE + 32'h8, 32'h01);

    // Single byte 0x55
    bus_write(BASE, 32'h55);
    @(negedge clk);
    chk("single txd before pop", {31'b0, txd}, 32'h1);
    rd_check("single status queued", BASE + 32'h4, 32'h10);
    @(negedge clk);
    chk("single start one cycle later", {31'b0, txd}, 32'h0);
    rd_check("single status active", BASE + 32'h4, 32'h06);
    check_frame(8'h55, "single");
    chk("single busy last stop cycle", {31'b0, busy}, 32'h1);
    @(negedge clk);
    chk("single busy drop", {31'b0, busy}, 32'h0);
    chk("single idle txd", {31'b0, txd}, 32'h1);

    // Back-to-back 0xA5, 0x3C
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h3C);
    @(negedge clk);
    rd_check("b2b status count1", BASE + 32'h4, 32'h14);
    check_frame(8'hA5, "b2b first");
    @(negedge clk);
    check_frame(8'h3C, "b2b second");
    @(negedge clk);
    chk("b2b busy drop", {31'b0, busy}, 32'h0);

    // Reset during data bit 3 of 0xF0 with 0x99 queued behind it
    bus_write(BASE, 32'hF0);
    bus_write(BASE, 32'h99);
    wait_start("midreset");
    repeat (16) @(negedge clk);
    chk("midreset bit3 low", {31'b0, txd}, 32'h0);
    reset = 1'b0;
    #1 chk("midreset txd async high", {31'b0, txd}, 32'h1);
    chk("midreset busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd_check("midreset status", BASE + 32'h4, 32'h02);
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) quiet = 1'b0;
    end
    chk("midreset txd stays high", {31'b0, quiet}, 32'h1);

    // Decode, register and overflow vectors
    tbl[0]  = '{1'b0, BASE + 32'h4,  32'h0,        32'h02};
    tbl[1]  = '{1'b0, BASE + 32'h8,  32'h0,        32'h01};
    tbl[2]  = '{1'b1, BASE + 32'h8,  32'h0,        32'h01};
    tbl[3]  = '{1'b0, BASE + 32'h8,  32'h0,        32'h00};
    tbl[4]  = '{1'b1, BASE + 32'hC,  32'h77,       32'h00};
    tbl[5]  = '{1'b1, BASE + 32'h10, 32'h77,       32'h00};
    tbl[6]  = '{1'b0, BASE + 32'h4,  32'h0,        32'h02};
    tbl[7]  = '{1'b1, BASE + 32'h0,  32'hFFFF_FF11, 32'h00};
    tbl[8]  = '{1'b0, BASE + 32'h4,  32'h0,        32'h10};
    tbl[9]  = '{1'b1, BASE + 32'h0,  32'h22,       32'h00};
    tbl[10] = '{1'b1, BASE + 32'h0,  32'h33,       32'h00};
    tbl[11] = '{1'b1, BASE + 32'h0,  32'h44,       32'h00};
    tbl[12] = '{1'b0, BASE + 32'h4,  32'h0,        32'h41};
    tbl[13] = '{1'b1, BASE + 32'h0,  32'h55,       32'h00};
    tbl[14] = '{1'b0, BASE + 32'h4,  32'h0,        32'h49};
    tbl[15] = '{1'b1, BASE + 32'h4,  32'h8,        32'h49};
    tbl[16] = '{1'b0, BASE + 32'h4,  32'h0,        32'h41};
    tbl[17] = '{1'b1, BASE + 32'h4,  32'h7,        32'h41};
    tbl[18] = '{1'b0, BASE + 32'h4,  32'h0,        32'h41};
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      we = tbl[i].we; a = tbl[i].a; wd = tbl[i].wd;
      #1 chk($sformatf("vec%0d rd", i), rd, tbl[i].exp_rd);
      @(posedge clk);
      #1 we = 1'b0;
    end
    chk("vec txd idle while disabled", {31'b0, txd}, 32'h1);

    // Enable: exactly the four queued bytes go out, contiguously
    bus_write(BASE + 32'h8, 32'h1);
    wait_start("drain");
    check_frame(8'h11, "drain0");
    @(negedge clk);
    check_frame(8'h22, "drain1");
    @(negedge clk);
    check_frame(8'h33, "drain2");
    @(negedge clk);
    check_frame(8'h44, "drain3");
    @(negedge clk);
    chk("drain busy drop", {31'b0, busy}, 32'h0);
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) quiet = 1'b0;
    end
    chk("drain no fifth frame", {31'b0, quiet}, 32'h1);
    rd_check("drain status", BASE + 32'h4, 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
